// File: rtl/gpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpu_pkg                                                                    |
// | Shared types for the FMA job sequencer: sequencer state encoding, the      |
// | read-tag record carried alongside in-flight line reads, and the check      |
// | that a memory line holds exactly three operand words per FMA lane.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package gpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    COLLECT = 2'd2,
    WRITE   = 2'd3
  } seq_state_t;

  // Tag travelling with each line read so the datapath knows which beat it is.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } flag_tag_t;

  // Each lane consumes a, b and c from the same line.
  localparam int unsigned OPERANDS_PER_LANE = 3;

  function automatic bit line_width_ok(input int unsigned fma_count,
                                       input int unsigned word_width,
                                       input int unsigned line_width);
    return line_width == OPERANDS_PER_LANE * word_width * fma_count;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flag_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | flag_delay_line                                                            |
// | Shift register of {valid, first, last} read tags, DEPTH stages deep, so    |
// | the tags line up with read data returning DEPTH cycles after the strobe.   |
// | Ports: clk, rst (async, active-high), tag_* in, dly_* out.                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module flag_delay_line
  import gpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tag_valid,
  input  logic tag_first,
  input  logic tag_last,
  output logic dly_valid,
  output logic dly_first,
  output logic dly_last
);

  flag_tag_t stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage[s] <= '0;
      end
    end else begin
      stage[0] <= '{valid: tag_valid, first: tag_first, last: tag_last};
      for (int s = 1; s < DEPTH; s++) begin
        stage[s] <= stage[s-1];
      end
    end
  end

  assign dly_valid = stage[DEPTH-1].valid;
  assign dly_first = stage[DEPTH-1].first;
  assign dly_last  = stage[DEPTH-1].last;

endmodule
`default_nettype wire

// File: rtl/fma_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fma_sequencer                                                              |
// | Runs one dot-product job: reads N consecutive lines and streams them to    |
// | the FMA lanes with first/last beat marks, collects one result per lane,    |
// | then holds a packed write request until the write buffer accepts it.      |
// | Ports:                                                                     |
// |   clk_in, rst_in (async, active-high)                                      |
// |   cmd_*      : job command handshake (addr, len, dest)                     |
// |   rd_*       : line memory read strobe/address and returned data           |
// |   abc_*, use_new_c_out, output_can_be_valid_out : FMA operand stream       |
// |   fma_out_in, fma_valid_in : per-lane results (lane 0 in MSBs)             |
// |   wr_*       : result write request, held until wr_ready_in                |
// |   busy_out, done_out, err_out : status                                     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fma_sequencer
  import gpu_pkg::*;
#(
  parameter int unsigned FMA_COUNT    = 2,
  parameter int unsigned WORD_WIDTH   = 16,
  parameter int unsigned LINE_WIDTH   = 96,
  parameter int unsigned ADDR_LENGTH  = 9,
  parameter int unsigned LEN_WIDTH    = 8,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            cmd_valid_in,
  output logic                            cmd_ready_out,
  input  logic [ADDR_LENGTH-1:0]          cmd_addr_in,
  input  logic [LEN_WIDTH-1:0]            cmd_len_in,
  input  logic [ADDR_LENGTH-1:0]          cmd_dest_in,
  output logic                            rd_en_out,
  output logic [ADDR_LENGTH-1:0]          rd_addr_out,
  input  logic [LINE_WIDTH-1:0]           rd_data_in,
  output logic [LINE_WIDTH-1:0]           abc_out,
  output logic                            abc_valid_out,
  output logic                            use_new_c_out,
  output logic                            output_can_be_valid_out,
  input  logic [WORD_WIDTH*FMA_COUNT-1:0] fma_out_in,
  input  logic [FMA_COUNT-1:0]            fma_valid_in,
  output logic                            wr_en_out,
  output logic [ADDR_LENGTH-1:0]          wr_addr_out,
  output logic [WORD_WIDTH*FMA_COUNT-1:0] wr_data_out,
  input  logic                            wr_ready_in,
  output logic                            busy_out,
  output logic                            done_out,
  output logic                            err_out
);

  if (!line_width_ok(FMA_COUNT, WORD_WIDTH, LINE_WIDTH)) begin : g_line_width_check
    $error("fma_sequencer: LINE_WIDTH must be 3*WORD_WIDTH*FMA_COUNT");
  end

  seq_state_t                     state, state_next;
  logic [ADDR_LENGTH-1:0]         base_addr, dest_addr;
  logic [LEN_WIDTH-1:0]           job_len, issue_idx;
  logic [FMA_COUNT-1:0]           lane_mask;
  logic [WORD_WIDTH*FMA_COUNT-1:0] results;
  logic                           err_q, zero_done;

  logic cmd_fire, issuing, last_issue, write_accept, stray_strobe, dup_strobe;
  logic [FMA_COUNT-1:0] mask_merged;
  logic dl_valid, dl_first, dl_last;

  assign cmd_fire     = cmd_valid_in && (state == IDLE);
  assign issuing      = (state == ISSUE);
  assign last_issue   = issuing && (issue_idx == job_len - LEN_WIDTH'(1));
  assign write_accept = (state == WRITE) && wr_ready_in;
  assign mask_merged  = lane_mask | fma_valid_in;
  // Results can only legitimately arrive once all beats have gone out.
  assign stray_strobe = ((state == IDLE) || (state == ISSUE)) && (|fma_valid_in);
  // In WRITE every mask bit is set, so any strobe there is a repeat too.
  assign dup_strobe   = ((state == COLLECT) || (state == WRITE)) &&
                        (|(fma_valid_in & lane_mask));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    cmd_ready_out = 1'b0;
    busy_out      = 1'b1;
    rd_en_out     = 1'b0;
    rd_addr_out   = '0;
    wr_en_out     = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready_out = 1'b1;
        busy_out      = 1'b0;
        // A zero-length job never leaves IDLE; it only produces a done pulse.
        if (cmd_valid_in && (cmd_len_in != '0)) state_next = ISSUE;
      end
      ISSUE: begin
        rd_en_out   = 1'b1;
        rd_addr_out = base_addr + ADDR_LENGTH'(issue_idx);
        if (last_issue) state_next = COLLECT;
      end
      COLLECT: begin
        if (&mask_merged) state_next = WRITE;
      end
      WRITE: begin
        wr_en_out = 1'b1;
        if (wr_ready_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      base_addr <= '0;
      dest_addr <= '0;
      job_len   <= '0;
      issue_idx <= '0;
      lane_mask <= '0;
      results   <= '0;
      err_q     <= 1'b0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= cmd_fire && (cmd_len_in == '0);
      if (cmd_fire) begin
        base_addr <= cmd_addr_in;
        dest_addr <= cmd_dest_in;
        job_len   <= cmd_len_in;
        issue_idx <= '0;
        lane_mask <= '0;
      end
      if (issuing) issue_idx <= issue_idx + LEN_WIDTH'(1);
      if (state == COLLECT) begin
        lane_mask <= mask_merged;
        // First strobe per lane wins; repeats are flagged, not captured.
        for (int lane = 0; lane < FMA_COUNT; lane++) begin
          if (fma_valid_in[lane] && !lane_mask[lane]) begin
            results[(FMA_COUNT-1-lane)*WORD_WIDTH +: WORD_WIDTH] <=
              fma_out_in[(FMA_COUNT-1-lane)*WORD_WIDTH +: WORD_WIDTH];
          end
        end
      end
      if (stray_strobe || dup_strobe) err_q <= 1'b1;
    end
  end

  flag_delay_line #(
    .DEPTH (READ_LATENCY)
  ) u_flag_delay_line (
    .clk       (clk_in),
    .rst       (rst_in),
    .tag_valid (issuing),
    .tag_first (issuing && (issue_idx == '0)),
    .tag_last  (last_issue),
    .dly_valid (dl_valid),
    .dly_first (dl_first),
    .dly_last  (dl_last)
  );

  // Read data is registered once more so the FMAs see a clean flop output;
  // abc_out is passed through whole, so lane 0 stays in the MSB slice.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      abc_out                 <= '0;
      abc_valid_out           <= 1'b0;
      use_new_c_out           <= 1'b0;
      output_can_be_valid_out <= 1'b0;
    end else begin
      abc_valid_out           <= dl_valid;
      use_new_c_out           <= dl_valid && dl_first;
      output_can_be_valid_out <= dl_valid && dl_last;
      if (dl_valid) abc_out <= rd_data_in;
    end
  end

  assign wr_addr_out = dest_addr;
  assign wr_data_out = results;
  assign err_out     = err_q;
  assign done_out    = zero_done || write_accept;

endmodule
`default_nettype wire

// File: tb/tb_fma_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fma_sequencer                                                           |
// | Self-checking bench: a line-memory model with fixed read latency, a       |
// | scoreboard of expected read addresses and operand beats, a table of jobs  |
// | and hand-written error / mid-job reset sequences.                          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fma_sequencer;

  localparam int FMA_COUNT    = 2;
  localparam int WORD_WIDTH   = 16;
  localparam int LINE_WIDTH   = 96;
  localparam int ADDR_LENGTH  = 9;
  localparam int LEN_WIDTH    = 8;
  localparam int READ_LATENCY = 2;

  logic                            clk_in = 1'b0;
  logic                            rst_in;
  logic                            cmd_valid_in;
  logic                            cmd_ready_out;
  logic [ADDR_LENGTH-1:0]          cmd_addr_in;
  logic [LEN_WIDTH-1:0]            cmd_len_in;
  logic [ADDR_LENGTH-1:0]          cmd_dest_in;
  logic                            rd_en_out;
  logic [ADDR_LENGTH-1:0]          rd_addr_out;
  logic [LINE_WIDTH-1:0]           rd_data_in;
  logic [LINE_WIDTH-1:0]           abc_out;
  logic                            abc_valid_out;
  logic                            use_new_c_out;
  logic                            output_can_be_valid_out;
  logic [WORD_WIDTH*FMA_COUNT-1:0] fma_out_in;
  logic [FMA_COUNT-1:0]            fma_valid_in;
  logic                            wr_en_out;
  logic [ADDR_LENGTH-1:0]          wr_addr_out;
  logic [WORD_WIDTH*FMA_COUNT-1:0] wr_data_out;
  logic                            wr_ready_in;
  logic                            busy_out;
  logic                            done_out;
  logic                            err_out;

  fma_sequencer #(
    .FMA_COUNT    (FMA_COUNT),
    .WORD_WIDTH   (WORD_WIDTH),
    .LINE_WIDTH   (LINE_WIDTH),
    .ADDR_LENGTH  (ADDR_LENGTH),
    .LEN_WIDTH    (LEN_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) dut (
    .clk_in                  (clk_in),
    .rst_in                  (rst_in),
    .cmd_valid_in            (cmd_valid_in),
    .cmd_ready_out           (cmd_ready_out),
    .cmd_addr_in             (cmd_addr_in),
    .cmd_len_in              (cmd_len_in),
    .cmd_dest_in             (cmd_dest_in),
    .rd_en_out               (rd_en_out),
    .rd_addr_out             (rd_addr_out),
    .rd_data_in              (rd_data_in),
    .abc_out                 (abc_out),
    .abc_valid_out           (abc_valid_out),
    .use_new_c_out           (use_new_c_out),
    .output_can_be_valid_out (output_can_be_valid_out),
    .fma_out_in              (fma_out_in),
    .fma_valid_in            (fma_valid_in),
    .wr_en_out               (wr_en_out),
    .wr_addr_out             (wr_addr_out),
    .wr_data_out             (wr_data_out),
    .wr_ready_in             (wr_ready_in),
    .busy_out                (busy_out),
    .done_out                (done_out),
    .err_out                 (err_out)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- line memory model ----------------
  function automatic logic [95:0] line_of(input logic [8:0] a);
    logic [15:0] w;
    w = {7'h00, a};
    return {w + 16'h1000, w + 16'h2000, w + 16'h3000,
            w + 16'h4000, w + 16'h5000, w + 16'h6000};
  endfunction

  logic [READ_LATENCY-1:0] mem_vld = '0;
  logic [ADDR_LENGTH-1:0]  mem_addr [READ_LATENCY];

  always @(posedge clk_in) begin
    mem_vld[0]  <= rd_en_out;
    mem_addr[0] <= rd_addr_out;
    for (int k = 1; k < READ_LATENCY; k++) begin
      mem_vld[k]  <= mem_vld[k-1];
      mem_addr[k] <= mem_addr[k-1];
    end
  end

  assign rd_data_in = mem_vld[READ_LATENCY-1] ? line_of(mem_addr[READ_LATENCY-1])
                                              : 96'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0;

  // ---------------- scoreboard / bookkeeping ----------------
  typedef struct packed {
    logic [95:0] line;
    logic        first;
    logic        last;
  } beat_t;

  typedef struct {
    logic [8:0]  addr;
    logic [7:0]  len;
    logic [8:0]  dest;
    logic [15:0] r0;
    logic [15:0] r1;
    int          skew;     // >0: lane 1 first, <0: lane 0 first, 0: together
    int          wr_wait;  // cycles wr_ready_in is held low
    logic        dup;      // re-strobe the first lane with another value
    logic [31:0] exp;
  } job_t;

  logic [8:0] rd_q[$];
  beat_t      beat_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int beats, rd_first, rd_last, abc_first, abc_last;

  logic        s_cmd_ready, s_busy, s_done, s_wr_en, s_err;
  logic [8:0]  s_wr_addr;
  logic [31:0] s_wr_data;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample at the falling edge, run the scoreboard, then return
  // just after the next rising edge so the caller can drive new inputs.
  task automatic cycle();
    beat_t b;
    @(negedge clk_in);
    cyc++;
    s_cmd_ready = cmd_ready_out;
    s_busy      = busy_out;
    s_done      = done_out;
    s_wr_en     = wr_en_out;
    s_wr_addr   = wr_addr_out;
    s_wr_data   = wr_data_out;
    s_err       = err_out;
    if (rd_en_out) begin
      if (rd_first < 0) rd_first = cyc;
      rd_last = cyc;
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_extra actual=addr %0d required=no read", rd_addr_out);
      end else begin
        check("rd_addr", rd_addr_out, rd_q.pop_front());
      end
    end
    if (abc_valid_out) begin
      if (abc_first < 0) abc_first = cyc;
      abc_last = cyc;
      beats++;
      if (beat_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL abc_extra actual=%0h required=no beat", abc_out);
      end else begin
        b = beat_q.pop_front();
        check("abc_data", abc_out, b.line);
        check("abc_flags", {use_new_c_out, output_can_be_valid_out}, {b.first, b.last});
      end
    end else begin
      check("flags_idle", {use_new_c_out, output_can_be_valid_out}, 2'b00);
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready_out, 1'b1);
    check({tag, "_quiet"}, {rd_en_out, abc_valid_out, use_new_c_out,
                            output_can_be_valid_out, wr_en_out, busy_out,
                            done_out, err_out}, 8'h00);
    check({tag, "_rd_addr"}, rd_addr_out, 9'd0);
    check({tag, "_abc"}, abc_out, 96'd0);
    check({tag, "_wr"}, {wr_addr_out, wr_data_out}, 41'd0);
  endtask

  task automatic push_expected(input logic [8:0] addr, input logic [7:0] len);
    logic [8:0] a;
    a = addr;
    for (int k = 0; k < int'(len); k++) begin
      rd_q.push_back(a);
      beat_q.push_back('{line: line_of(a), first: (k == 0), last: (k == int'(len) - 1)});
      a = a + 9'd1;
    end
  endtask

  task automatic strobe_lane(input int lane, input logic [15:0] v);
    fma_valid_in = (lane == 0) ? 2'b01 : 2'b10;
    fma_out_in   = (lane == 0) ? {v, 16'hDEAD} : {16'hDEAD, v};
    cycle();
    fma_valid_in = 2'b00;
    fma_out_in   = 32'hFFFF_FFFF;
  endtask

  task automatic run_job(input job_t j);
    int t0, guard, first_lane, gap;
    logic [15:0] first_val, second_val;
    cmd_valid_in = 1'b1;
    cmd_addr_in  = j.addr;
    cmd_len_in   = j.len;
    cmd_dest_in  = j.dest;
    push_expected(j.addr, j.len);
    rd_first = -1; rd_last = -1; abc_first = -1; abc_last = -1; beats = 0;
    cycle();
    t0 = cyc;
    check("cmd_ready_accept", s_cmd_ready, 1'b1);
    cmd_valid_in = 1'b0;
    if (j.len == 0) begin
      cycle();
      check("zero_done", {s_done, s_cmd_ready, s_busy, s_wr_en}, 4'b1100);
      cycle();
      check("zero_done_clear", s_done, 1'b0);
      check("zero_no_reads", rd_first, -1);
      return;
    end
    guard = 0;
    while (beats < int'(j.len) && guard < 200) begin
      cycle();
      guard++;
    end
    if (beats < int'(j.len)) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout actual=%0d beats required=%0d", beats, j.len);
    end
    check("rd_first_cyc", rd_first, t0 + 1);
    check("rd_last_cyc", rd_last, t0 + int'(j.len));
    check("abc_first_cyc", abc_first, t0 + READ_LATENCY + 2);
    check("abc_last_cyc", abc_last, t0 + int'(j.len) + READ_LATENCY + 1);
    check("busy_in_job", {s_busy, s_cmd_ready, s_wr_en}, 3'b100);

    if (j.skew == 0) begin
      fma_valid_in = 2'b11;
      fma_out_in   = {j.r0, j.r1};
      cycle();
      fma_valid_in = 2'b00;
    end else begin
      first_lane = (j.skew > 0) ? 1 : 0;
      gap        = (j.skew > 0) ? j.skew : -j.skew;
      first_val  = (first_lane == 1) ? j.r1 : j.r0;
      second_val = (first_lane == 1) ? j.r0 : j.r1;
      strobe_lane(first_lane, first_val);
      for (int g = 1; g < gap; g++) begin
        if (g == 1 && j.dup) strobe_lane(first_lane, ~first_val);
        else cycle();
        check("wait_no_write", s_wr_en, 1'b0);
      end
      strobe_lane(1 - first_lane, second_val);
    end
    check("collect_no_write", s_wr_en, 1'b0);

    wr_ready_in = 1'b0;
    for (int w = 0; w < j.wr_wait; w++) begin
      cycle();
      check("wr_hold_en", {s_wr_en, s_done}, 2'b10);
      check("wr_hold_data", s_wr_data, j.exp);
      check("wr_hold_addr", s_wr_addr, j.dest);
    end
    wr_ready_in = 1'b1;
    cycle();
    wr_ready_in = 1'b0;
    check("wr_accept", {s_wr_en, s_done, s_cmd_ready}, 3'b110);
    check("wr_data", s_wr_data, j.exp);
    check("wr_addr", s_wr_addr, j.dest);
    cycle();
    check("after_done", {s_cmd_ready, s_busy, s_done, s_wr_en}, 4'b1000);
  endtask

  job_t jobs[5];

  initial begin
    jobs[0] = '{9'd10,  8'd4, 9'h020, 16'h0400, 16'h0123,  3, 5, 1'b0, 32'h0400_0123};
    jobs[1] = '{9'd510, 8'd4, 9'h1FF, 16'hBEEF, 16'h1234,  0, 0, 1'b0, 32'hBEEF_1234};
    jobs[2] = '{9'd100, 8'd1, 9'h003, 16'h00AA, 16'h5500, -2, 1, 1'b0, 32'h00AA_5500};
    jobs[3] = '{9'd7,   8'd0, 9'h009, 16'h0000, 16'h0000,  0, 0, 1'b0, 32'h0000_0000};
    jobs[4] = '{9'd300, 8'd6, 9'h155, 16'hFFFF, 16'h0001,  1, 2, 1'b0, 32'hFFFF_0001};

    rst_in       = 1'b1;
    cmd_valid_in = 1'b0;
    cmd_addr_in  = '0;
    cmd_len_in   = '0;
    cmd_dest_in  = '0;
    fma_out_in   = '0;
    fma_valid_in = '0;
    wr_ready_in  = 1'b0;
    rd_first = -1; rd_last = -1; abc_first = -1; abc_last = -1; beats = 0;

    cycle();
    cycle();
    check_reset_values("reset");
    rst_in = 1'b0;
    cycle();

    for (int i = 0; i < 5; i++) begin
      run_job(jobs[i]);
    end
    check("err_clean", s_err, 1'b0);

    // Duplicate lane-1 strobe in COLLECT: first value kept, error raised.
    run_job('{9'd20, 8'd2, 9'h040, 16'h1111, 16'h2222, 2, 0, 1'b1, 32'h1111_2222});
    check("err_dup", s_err, 1'b1);

    // Reset clears the sticky error; a stray strobe in IDLE sets it again.
    rst_in = 1'b1;
    cycle();
    check("err_reset", err_out, 1'b0);
    rst_in = 1'b0;
    fma_valid_in = 2'b01;
    cycle();
    fma_valid_in = 2'b00;
    cycle();
    check("err_stray", s_err, 1'b1);
    run_job('{9'd60, 8'd3, 9'h0AA, 16'h0F0F, 16'hF0F0, -1, 0, 1'b0, 32'h0F0F_F0F0});
    check("err_sticky", s_err, 1'b1);

    // Reset after two of four reads: in-flight reads must never surface.
    cmd_valid_in = 1'b1;
    cmd_addr_in  = 9'd40;
    cmd_len_in   = 8'd4;
    cmd_dest_in  = 9'h033;
    push_expected(9'd40, 8'd4);
    rd_first = -1;
    cycle();
    cmd_valid_in = 1'b0;
    cycle();
    cycle();
    check("mid_reads_done", rd_q.size(), 2);
    rst_in = 1'b1;
    #1;
    check_reset_values("midrst");
    rd_q.delete();
    beat_q.delete();
    beats = 0;
    cycle();
    rst_in = 1'b0;
    repeat (6) cycle();
    check("midrst_no_beats", beats, 0);

    run_job('{9'd5, 8'd2, 9'h011, 16'h7777, 16'h8888, 0, 1, 1'b0, 32'h7777_8888});
    check("final_err", s_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
